// File: rtl/updown_count_controller.sv
// rtl/updown_count_controller.sv - up/down count sequencer with prescaler, limit actions and BCD digits
module updown_count_controller #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clock_i,
    input  logic       clear_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       dir_i,
    input  logic [1:0] mode_i,
    input  logic [3:0] lo_limit_i,
    input  logic [3:0] hi_limit_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] qn_o,
    output logic       count_dir_o,
    output logic       running_o,
    output logic       tick_o,
    output logic       terminal_o,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] PRE_MAX = 4'(PRESCALE - 1);

    state_t     state_q, state_d;
    logic [3:0] qn_q, qn_d;
    logic       dir_q, dir_d;
    logic [3:0] pre_q, pre_d;
    logic       term_q, term_d;
    logic       limits_ok;
    logic       at_limit;

    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            state_q <= IDLE;
            qn_q    <= 4'd0;
            dir_q   <= 1'b0;
            pre_q   <= 4'd0;
            term_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qn_q    <= qn_d;
            dir_q   <= dir_d;
            pre_q   <= pre_d;
            term_q  <= term_d;
        end
    end

    assign limits_ok = (lo_limit_i <= hi_limit_i);
    assign tick_o    = (state_q == RUN) && (pre_q == PRE_MAX) && !load_i && !stop_i;
    // A count outside the window counts as "at the limit" so the first step pulls it back in.
    assign at_limit  = dir_q ? (qn_q <= lo_limit_i) : (qn_q >= hi_limit_i);

    always_comb begin
        state_d = state_q;
        qn_d    = qn_q;
        dir_d   = dir_q;
        pre_d   = pre_q;
        term_d  = 1'b0;

        case (state_q)
            RUN: begin
                if (stop_i || !limits_ok) begin
                    state_d = IDLE;
                    pre_d   = 4'd0;
                end else begin
                    pre_d = (pre_q == PRE_MAX) ? 4'd0 : pre_q + 4'd1;
                    if (tick_o) begin
                        if (!at_limit) begin
                            qn_d = dir_q ? qn_q - 4'd1 : qn_q + 4'd1;
                        end else begin
                            term_d = 1'b1;
                            case (mode_i)
                                2'b01:   state_d = DONE;
                                2'b10:   dir_d   = ~dir_q;
                                default: qn_d    = dir_q ? hi_limit_i : lo_limit_i;
                            endcase
                        end
                    end
                end
            end
            default: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (start_i && limits_ok) begin
                    state_d = RUN;
                    dir_d   = dir_i;
                    pre_d   = 4'd0;
                end
            end
        endcase

        // Load wins over any step; tick is already suppressed so no terminal is raised.
        if (load_i) begin
            qn_d  = load_val_i;
            pre_d = 4'd0;
        end
    end

    assign qn_o        = qn_q;
    assign count_dir_o = dir_q;
    assign running_o   = (state_q == RUN);
    assign terminal_o  = term_q;
    assign tens_o      = (qn_q >= 4'd10) ? 4'd1 : 4'd0;
    assign ones_o      = (qn_q >= 4'd10) ? qn_q - 4'd10 : qn_q;

endmodule
